lab2_qsys_nios2_gen2_0_cpu_debug_ocimem_ctrl: RTL and testbench
===============================================================

LAB2_QSYS_NIOS2_GEN2_0_CPU_DEBUG_OCIMEM_CTRL -- requirements
Module: lab2_qsys_nios2_gen2_0_cpu_debug_ocimem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9: debug-memory word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum number of wait cycles per access (used only with REQ-030).
REQ-003 SHALL have port clk, input, 1: single system clock; all state on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port jdo, input, 38: debug command payload, valid in the cycle of any take_* pulse.
REQ-006 SHALL have port take_action_ocimem_a, input, 1: one-cycle pulse, address load.
REQ-007 SHALL have port take_no_action_ocimem_a, input, 1: one-cycle pulse, read at the current address.
REQ-008 SHALL have port take_action_ocimem_b, input, 1: one-cycle pulse, write at the current address.
REQ-009 SHALL have ports mem_addr (output, ADDR_W), mem_wdata (output, 32), mem_read (output, 1), mem_write (output, 1), mem_rdata (input, 32) and mem_waitrequest (input, 1): these form the debug-memory master port.
REQ-010 SHALL have ports MonDReg (output, 32), monitor_ready (output, 1) and monitor_error (output, 1): read data and status returned to the debug slave.

Function
REQ-011 SHALL implement the states IDLE, RD, WR and DONE.
REQ-012 Command decode in IDLE SHALL use the priority take_action_ocimem_b > take_action_ocimem_a > take_no_action_ocimem_a; the lower-priority pulses in the same cycle are discarded.
REQ-013 Address load SHALL set addr <= jdo[17+ADDR_W-1:17]; if jdo[35]=1, the block SHALL go to RD at the new address in the next cycle, otherwise it stays in IDLE with monitor_ready unchanged.
REQ-014 Read SHALL go to RD with mem_read=1 and mem_addr=addr, held stable until a cycle in which mem_waitrequest=0.
REQ-015 In the RD cycle where mem_waitrequest=0, the block SHALL capture MonDReg <= mem_rdata, increment addr, and go to DONE.
REQ-016 Write SHALL latch wdata <= jdo[34:3] and go to WR with mem_write=1, mem_addr=addr and mem_wdata held until mem_waitrequest=0; it then increments addr and goes to DONE.
REQ-017 mem_read and mem_write SHALL never both be 1 and SHALL be 0 outside RD and WR.
REQ-018 Accepting any read or write SHALL clear monitor_ready and monitor_error in the same edge.
REQ-019 DONE SHALL set monitor_ready=1 and return to IDLE after exactly one cycle. Minimum command-to-ready latency is 2 cycles, or 3 for an address load with read.
REQ-020 addr increment SHALL be modulo 2^ADDR_W: all-ones wraps to 0 with no error.
REQ-021 Any take_* pulse arriving in RD, WR or DONE SHALL be ignored and SHALL set monitor_error=1 (overrun); the operation in flight completes unaffected.
REQ-022 MonDReg SHALL change only in RD completion and hold its value otherwise, including across writes.

Reset
REQ-023 reset_n low SHALL asynchronously force state=IDLE, addr=0, wdata=0, MonDReg=0, mem_read=0, mem_write=0, monitor_ready=1 and monitor_error=0.
REQ-024 Reset asserted mid-access SHALL abandon that access; no addr increment and no MonDReg update occurs.
REQ-025 After deassertion, the first take_* pulse SHALL be accepted on the first rising edge.

Configuration
REQ-030 With macro OCIMEM_TIMEOUT_EN defined, an 8-bit-minimum wait counter SHALL count cycles in RD or WR with mem_waitrequest=1.
REQ-031 With OCIMEM_TIMEOUT_EN defined, when that count reaches TIMEOUT the block SHALL drop the request, leave addr and MonDReg unchanged, set monitor_error=1, and go to DONE.
REQ-032 Without OCIMEM_TIMEOUT_EN, no counter SHALL exist, the block SHALL wait indefinitely, and monitor_error SHALL be set only by overrun.

Verification
REQ-040 Pulse take_action_ocimem_a with jdo[25:17]=0x010 and jdo[35]=1, with mem_rdata=0xDEADBEEF and waitrequest=0 -> mem_read with mem_addr=0x010 for 1 cycle, MonDReg=0xDEADBEEF, monitor_ready=1 three cycles after the pulse, addr=0x011.
REQ-041 Pulse take_action_ocimem_b with jdo[34:3]=0x12345678 at addr=0x1FF, with waitrequest high for 3 cycles -> mem_write held 4 cycles with data 0x12345678, then addr=0x000 and monitor_error=0.
REQ-042 Pulse take_no_action_ocimem_a during WR -> that pulse is ignored, monitor_error=1 after DONE, and the write still completes.
REQ-043 Pulse all three take_* inputs in the same cycle -> only the write executes, and addr increments once.
REQ-044 With OCIMEM_TIMEOUT_EN defined and TIMEOUT=4, hold waitrequest=1 on a read -> mem_read drops after 4 cycles, monitor_error=1, and MonDReg and addr are unchanged.
REQ-045 Assert reset_n=0 during RD -> mem_read=0 immediately, monitor_ready=1, and addr=0.

Source files
------------

// File: rtl/lab2_qsys_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv
// OCI debug-memory access controller: address load, read and write commands to a waitrequest master.
// Optional macro OCIMEM_TIMEOUT_EN bounds each access to TIMEOUT wait cycles.
module lab2_qsys_nios2_gen2_0_cpu_debug_ocimem_ctrl #(
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_waitrequest,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr, addr_nx;
   logic [31:0]       wdata, wdata_nx;
   logic [31:0]       mon_q, mon_nx;
   logic              rdy_q, rdy_nx;
   logic              err_q, err_nx;
   logic              pend_q, pend_nx;
   logic              any_take;
   logic              expire;
   logic              unused_jdo;

   assign any_take   = take_action_ocimem_a | take_no_action_ocimem_a |
                       take_action_ocimem_b;
   assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

`ifdef OCIMEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [CNT_W-1:0] cnt, cnt_nx;

   // The cycle that would be the TIMEOUT-th wait cycle abandons the access.
   assign expire = mem_waitrequest && (cnt == CNT_W'(TIMEOUT - 1));

   always_comb begin
      cnt_nx = '0;
      if ((state == RD || state == WR) && mem_waitrequest)
         cnt_nx = cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt <= '0;
      else          cnt <= cnt_nx;
   end
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      addr_nx  = addr;
      wdata_nx = wdata;
      mon_nx   = mon_q;
      rdy_nx   = rdy_q;
      err_nx   = err_q;
      pend_nx  = 1'b0;
      unique case (state)
         IDLE: begin
            // A loaded address with read needs one cycle before RD starts.
            if (pend_q) begin
               state_nx = RD;
               if (any_take) err_nx = 1'b1;
            end else if (take_action_ocimem_b) begin
               wdata_nx = jdo[34:3];
               state_nx = WR;
               rdy_nx   = 1'b0;
               err_nx   = 1'b0;
            end else if (take_action_ocimem_a) begin
               addr_nx = jdo[17 +: ADDR_W];
               if (jdo[35]) begin
                  pend_nx = 1'b1;
                  rdy_nx  = 1'b0;
                  err_nx  = 1'b0;
               end
            end else if (take_no_action_ocimem_a) begin
               state_nx = RD;
               rdy_nx   = 1'b0;
               err_nx   = 1'b0;
            end
         end
         RD: begin
            if (any_take) err_nx = 1'b1;
            if (expire) begin
               err_nx   = 1'b1;
               state_nx = DONE;
            end else if (!mem_waitrequest) begin
               mon_nx   = mem_rdata;
               addr_nx  = addr + ADDR_W'(1);
               state_nx = DONE;
            end
         end
         WR: begin
            if (any_take) err_nx = 1'b1;
            if (expire) begin
               err_nx   = 1'b1;
               state_nx = DONE;
            end else if (!mem_waitrequest) begin
               addr_nx  = addr + ADDR_W'(1);
               state_nx = DONE;
            end
         end
         DONE: begin
            if (any_take) err_nx = 1'b1;
            rdy_nx   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         addr   <= '0;
         wdata  <= '0;
         mon_q  <= '0;
         rdy_q  <= 1'b1;
         err_q  <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         state  <= state_nx;
         addr   <= addr_nx;
         wdata  <= wdata_nx;
         mon_q  <= mon_nx;
         rdy_q  <= rdy_nx;
         err_q  <= err_nx;
         pend_q <= pend_nx;
      end
   end

   assign mem_read      = (state == RD);
   assign mem_write     = (state == WR);
   assign mem_addr      = addr;
   assign mem_wdata     = wdata;
   assign MonDReg       = mon_q;
   assign monitor_ready = rdy_q;
   assign monitor_error = err_q;

endmodule

// File: tb/tb_lab2_qsys_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv
// Scoreboard bench for the OCI debug-memory controller with a waitrequest memory slave.
// Define OCIMEM_TIMEOUT_EN to also exercise the access timeout with TIMEOUT=4.
module tb_lab2_qsys_nios2_gen2_0_cpu_debug_ocimem_ctrl;

`ifdef OCIMEM_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif
   localparam int AW = 9;
   localparam int DEPTH = 512;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [37:0]   jdo = '0;
   logic          take_action_ocimem_a = 1'b0;
   logic          take_no_action_ocimem_a = 1'b0;
   logic          take_action_ocimem_b = 1'b0;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_read;
   logic          mem_write;
   logic [31:0]   mem_rdata = '0;
   logic          mem_waitrequest = 1'b0;
   logic [31:0]   MonDReg;
   logic          monitor_ready;
   logic          monitor_error;

   lab2_qsys_nios2_gen2_0_cpu_debug_ocimem_ctrl #(
      .ADDR_W(AW),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .jdo(jdo),
      .take_action_ocimem_a(take_action_ocimem_a),
      .take_no_action_ocimem_a(take_no_action_ocimem_a),
      .take_action_ocimem_b(take_action_ocimem_b),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_rdata(mem_rdata),
      .mem_waitrequest(mem_waitrequest),
      .MonDReg(MonDReg),
      .monitor_ready(monitor_ready),
      .monitor_error(monitor_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] mon;
      int          addr;
      bit          err;
      int          lat;
      int          acc;
      int          edge_a;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] slv_mem[DEPTH];
   logic [31:0] ref_mem[DEPTH];
   int          ref_addr = 0;
   logic [31:0] ref_mon = '0;
   int          wait_left = 0;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          acc_cnt = 0;
   bit          prev_rdy = 1'b1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   always @(posedge clk) cyc++;

   // Memory slave: stalls for wait_left access cycles, then completes.
   always @(negedge clk) begin
      mem_waitrequest = 1'b0;
      if (mem_read || mem_write) begin
         if (wait_left > 0) begin
            mem_waitrequest = 1'b1;
            wait_left--;
         end else if (mem_write) begin
            slv_mem[mem_addr] = mem_wdata;
         end
      end
      mem_rdata = slv_mem[mem_addr];
   end

   // Monitor: each rising monitor_ready closes one expected transaction.
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         exp_q.delete();
         acc_cnt = 0;
         prev_rdy = 1'b1;
      end else begin
         if (mem_read || mem_write) acc_cnt++;
         chk("rd_wr_excl", 64'(mem_read & mem_write), 64'd0);
         if (monitor_ready && !prev_rdy) begin
            chk("expected_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("MonDReg", 64'(MonDReg), 64'(e.mon));
               chk("addr", 64'(mem_addr), 64'(e.addr));
               chk("monitor_error", 64'(monitor_error), 64'(e.err));
               chk("latency", 64'(cyc - e.edge_a), 64'(e.lat));
               chk("access_cycles", 64'(acc_cnt), 64'(e.acc));
            end
            acc_cnt = 0;
         end
         prev_rdy = monitor_ready;
      end
   end

   task automatic pulse(input bit a, input bit na, input bit b,
                        input logic [37:0] j);
      jdo = j;
      take_action_ocimem_a = a;
      take_no_action_ocimem_a = na;
      take_action_ocimem_b = b;
      @(negedge clk);
      take_action_ocimem_a = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   // kind: 0 load, 1 load+read, 2 read, 3 write; all3 pulses every take_*.
   task automatic issue(input int kind, input int a9, input logic [31:0] d,
                        input int w, input bit all3);
      logic [37:0] j;
      exp_t e;
      j = 38'({$urandom(), $urandom()});
      wait_left = w;
      if (kind <= 1) begin
         j[25:17] = 9'(a9);
         j[35] = (kind == 1);
         ref_addr = a9;
      end
      if (kind == 3) j[34:3] = d;
      if (kind != 0) begin
         e.acc = w + 1;
         e.err = 1'b0;
         e.edge_a = cyc + 1;
         if (kind == 3) begin
            ref_mem[ref_addr] = d;
            e.lat = 2 + w;
         end else begin
            ref_mon = ref_mem[ref_addr];
            e.lat = (kind == 1) ? 3 + w : 2 + w;
         end
         ref_addr = (ref_addr + 1) % DEPTH;
         e.mon = ref_mon;
         e.addr = ref_addr;
         exp_q.push_back(e);
      end
      pulse(all3 || kind <= 1, all3 || kind == 2, kind == 3, j);
   endtask

   initial begin
      logic [31:0] v;
      for (int i = 0; i < DEPTH; i++) begin
         v = $urandom();
         slv_mem[i] = v;
         ref_mem[i] = v;
      end
      slv_mem[16] = 32'hDEADBEEF;
      ref_mem[16] = 32'hDEADBEEF;

      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(monitor_ready), 64'd1);
      chk("rst_error", 64'(monitor_error), 64'd0);
      chk("rst_read", 64'(mem_read), 64'd0);
      chk("rst_write", 64'(mem_write), 64'd0);
      chk("rst_mondreg", 64'(MonDReg), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      issue(1, 'h010, '0, 0, 1'b0);
      drain();

      issue(0, 'h1FF, '0, 0, 1'b0);
      issue(3, 0, 32'h12345678, 3, 1'b0);
      drain();
      issue(1, 'h1FF, '0, 0, 1'b0);
      drain();

      issue(3, 0, $urandom(), 3, 1'b0);
      exp_q[exp_q.size() - 1].err = 1'b1;
      pulse(1'b0, 1'b1, 1'b0, 38'({$urandom(), $urandom()}));
      drain();
      issue(2, 0, '0, 0, 1'b0);
      exp_q[exp_q.size() - 1].mon = ref_mem[(ref_addr + DEPTH - 1) % DEPTH];
      drain();

      issue(0, 'h055, '0, 0, 1'b0);
      issue(3, 0, $urandom(), 1, 1'b1);
      drain();

      for (int n = 0; n < 80; n++) begin
         int k;
         int a;
         k = $urandom_range(0, 3);
         a = ($urandom_range(0, 7) == 0) ? DEPTH - 1 : $urandom_range(0, DEPTH - 1);
         issue(k, a, $urandom(), $urandom_range(0, 3), 1'b0);
         drain();
      end

`ifdef OCIMEM_TIMEOUT_EN
      begin
         exp_t e;
         e.mon = ref_mon;
         e.addr = ref_addr;
         e.err = 1'b1;
         e.lat = 1 + TO;
         e.acc = TO;
         e.edge_a = cyc + 1;
         exp_q.push_back(e);
         wait_left = 20;
         pulse(1'b0, 1'b1, 1'b0, '0);
         drain();
         wait_left = 0;
      end
`endif

      wait_left = 50;
      pulse(1'b0, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("pre_rst_in_rd", 64'(mem_read), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_read", 64'(mem_read), 64'd0);
      chk("midrst_ready", 64'(monitor_ready), 64'd1);
      chk("midrst_addr", 64'(mem_addr), 64'd0);
      chk("midrst_mondreg", 64'(MonDReg), 64'd0);
      @(negedge clk);
      wait_left = 0;
      ref_addr = 0;
      ref_mon = '0;
      #1 reset_n = 1'b1;
      @(negedge clk);
      issue(2, 0, '0, 0, 1'b0);
      drain();
      issue(2, 0, '0, 2, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
